// File: rtl/instr_loader_if.sv
// Host-side byte stream, memory write port and status/control signals of the instruction loader.
// The master drives the stream and start request; the slave (the loader) drives everything else.
interface instr_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-3:0] load_len;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  busy;
  logic                  done;
  logic [7:0]            checksum;
  logic                  core_rst;

  modport master (
    output start,
    output load_len,
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  busy,
    input  done,
    input  checksum,
    input  core_rst
  );

  modport slave (
    input  start,
    input  load_len,
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data,
    output busy,
    output done,
    output checksum,
    output core_rst
  );
endinterface

// File: rtl/instr_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to instruction memory at
// consecutive word addresses, holding the core in reset until the requested word count is written.
module instr_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  instr_loader_if.slave bus
);

  localparam int unsigned LEN_WIDTH = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } state_e;

  state_e                state_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  word_idx_q;
  logic [1:0]            byte_cnt_q;
  logic [31:0]           word_q;
  logic [7:0]            checksum_q;

  logic                  in_ready_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [31:0]           wr_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  core_rst_q;

  logic [31:0]           word_next;
  logic [LEN_WIDTH-1:0]  word_idx_next;
  logic                  accept;

  assign accept        = bus.in_valid && in_ready_q;
  assign word_idx_next = word_idx_q + 1'b1;

  // Current word with the incoming byte merged into its lane.
  always_comb begin
    word_next = word_q;
    unique case (byte_cnt_q)
      2'd0: word_next[7:0]   = bus.in_data;
      2'd1: word_next[15:8]  = bus.in_data;
      2'd2: word_next[23:16] = bus.in_data;
      2'd3: word_next[31:24] = bus.in_data;
      default: word_next = word_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      checksum_q <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            len_q      <= bus.load_len;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            checksum_q <= '0;
            if (bus.load_len == '0) begin
              state_q    <= StDone;
              done_q     <= 1'b1;
              core_rst_q <= 1'b0;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b0;
            end else begin
              state_q    <= StRecv;
              done_q     <= 1'b0;
              core_rst_q <= 1'b1;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
            end
          end
        end

        StRecv: begin
          if (accept) begin
            word_q     <= word_next;
            checksum_q <= checksum_q ^ bus.in_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q    <= StWrite;
              in_ready_q <= 1'b0;
              wr_en_q    <= 1'b1;
              wr_addr_q  <= {word_idx_q, 2'b00};
              wr_data_q  <= word_next;
            end
          end
        end

        StWrite: begin
          word_idx_q <= word_idx_next;
          if (word_idx_next == len_q) begin
            state_q    <= StDone;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            core_rst_q <= 1'b0;
            in_ready_q <= 1'b0;
          end else begin
            state_q    <= StRecv;
            in_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.checksum = checksum_q;
  assign bus.core_rst = core_rst_q;

  // Structural invariants of the write port and status outputs.
  wr_en_single_cycle : assert property (@(posedge clk) disable iff (rst)
    wr_en_q |=> !wr_en_q);
  wr_blocks_stream : assert property (@(posedge clk) disable iff (rst)
    wr_en_q |-> !in_ready_q);
  wr_addr_aligned : assert property (@(posedge clk) disable iff (rst)
    wr_en_q |-> (wr_addr_q[1:0] == 2'b00));
  done_releases_core : assert property (@(posedge clk) disable iff (rst)
    done_q |-> (!core_rst_q && !busy_q));

endmodule

// File: doc/instr_loader.md
# instr_loader

Write-side companion to the instruction memory: receives a program as a byte stream over a valid/ready handshake, packs each four consecutive bytes little-endian into a 32-bit instruction, and issues one word write per instruction into the byte-addressed instruction memory at PC-aligned addresses 0, 4, 8, and so on. It holds the processor core in reset while loading and releases it once the requested number of words has been written. It sits between the host/boot interface and the instruction memory's write port.

## Interface
- ADDR_WIDTH, 8, byte-address width of instruction memory; word count width LEN_WIDTH = ADDR_WIDTH-2
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a load of load_len words
- load_len  in  ADDR_WIDTH-2  number of 32-bit words to load; sampled on accepted start
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader can accept a byte this cycle
- wr_en  out  1  word write strobe to instruction memory
- wr_addr  out  ADDR_WIDTH  byte address of word, always a multiple of 4
- wr_data  out  32  packed word; wr_data[7:0] lands at wr_addr+0, [31:24] at wr_addr+3
- busy  out  1  load in progress
- done  out  1  last load completed; held until next accepted start
- checksum  out  8  running XOR of all bytes accepted in current/last load
- core_rst  out  1  reset to processor core; high from reset until load completes

## Operation
- States: IDLE, RECV, WRITE, DONE.
- Reset (async): state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, checksum=0, core_rst=1; byte counter and word index =0.
- IDLE: on start, latch load_len, clear word index, byte counter, checksum and done; core_rst=1. load_len=0 -> DONE; otherwise -> RECV.
- RECV: in_ready=1, busy=1. Byte accepted when in_valid & in_ready at an edge: in_data shifted into lane byte_cnt (lane 0 = bits [7:0]), checksum ^= in_data, byte_cnt++ (2-bit, wraps). On 4th byte (byte_cnt==3) -> WRITE.
- WRITE: one cycle; wr_en=1, wr_addr={word_idx,2'b00}, wr_data=assembled word, in_ready=0. Then word_idx++; if new word_idx==latched length -> DONE, else RECV.
- DONE: busy=0, done=1, core_rst=0, in_ready=0. start -> behaves as from IDLE (re-asserts core_rst on the next edge, clears done).
- start while busy (RECV/WRITE) ignored; load_len changes after acceptance ignored.
- in_valid while in_ready=0: byte not consumed; source must hold it.
- Maximum length 2^(ADDR_WIDTH-2)-1 words; last address never exceeds memory (no wrap).
- rst mid-load: immediate abort to reset values; partial words discarded; core_rst=1.

## Timing
- in_ready, wr_en, busy, done, core_rst are registered (state-decoded from registered state); no combinational path in_valid -> in_ready.
- Per word: minimum 5 cycles (4 accept cycles + 1 WRITE); gaps in in_valid extend RECV only.
- wr_en pulses exactly one cycle per word; wr_addr/wr_data valid in the same cycle as wr_en.
- done and core_rst=0 assert the cycle after the final WRITE cycle.
- Start accepted at edge N -> in_ready=1 in cycle N+1 (load_len>0) or done=1 in cycle N+1 (load_len=0).
- checksum updated on the edge that accepts a byte; stable in DONE.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs at reset values immediately, core_rst=1, done=0.
- Single word: start, load_len=1, bytes 00,00,22,00 back-to-back -> one wr_en with wr_addr=0x00, wr_data=0x00220000 five cycles after first accept; done=1, core_rst=0 next cycle; checksum=0x22.
- Three words with in_valid gaps (idle 2 cycles between bytes) -> writes at 0x00, 0x04, 0x08 in order, data correct, no extra wr_en, in_ready low in each WRITE cycle.
- load_len=0 -> no wr_en, no byte accepted, done=1 one cycle after start.
- start pulsed during RECV with different load_len -> ignored; load completes with original count.
- rst during second word of a 4-word load, then new load of 1 word 0x11223344 (bytes 44,33,22,11) -> only wr_addr=0x00 written with 0x11223344; checksum=0x44.
